// File: rtl/alu_pkg.sv
// Shared types and constants for the registered sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
    OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
    OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Divide-by-zero result; sliced down to WIDTH at the point of use.
  localparam logic [31:0] DIV_ZERO_RESULT = '1;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per clock. quotient/remainder show the
// value the current step produces, so they are final while last is high.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             running;

  assign running = (cnt_q != CW'(WIDTH));
  assign last    = running && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    // Negative trial difference (MSB set) means restore the shifted value.
    if (!diff[WIDTH]) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign quotient  = step_quo;
  assign remainder = step_rem;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (running) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= CW'(WIDTH);
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered 16-op ALU with start/done handshake, status flags and a
// multi-cycle restoring divider for DIV with a nonzero divisor.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             zero,
  output logic             div_zero,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_d, b_d, result_q, result_d, rem_q, rem_d;
  logic             carry_q, carry_d, zero_q, zero_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             div_load, div_last;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   ex_res, ex_rem;
  logic               ex_carry, ex_dz;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (a_in),
    .divisor   (b_in),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  always_comb begin
    ex_res   = '0;
    ex_rem   = '0;
    ex_carry = 1'b0;
    ex_dz    = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    case (op_q)
      OP_ADD:  begin ex_res = sum[WIDTH-1:0]; ex_carry = sum[WIDTH]; end
      OP_SUB:  begin ex_res = a_q - b_q; ex_carry = (a_q < b_q); end
      OP_MUL:  begin ex_res = prod[WIDTH-1:0]; ex_carry = |prod[2*WIDTH-1:WIDTH]; end
      // Only a zero divisor reaches EXEC with DIV.
      OP_DIV:  begin ex_res = DIV_ZERO_RESULT[WIDTH-1:0]; ex_rem = a_q; ex_dz = 1'b1; end
      OP_SHL:  begin ex_res = {a_q[WIDTH-2:0], 1'b0}; ex_carry = a_q[WIDTH-1]; end
      OP_SHR:  begin ex_res = {1'b0, a_q[WIDTH-1:1]}; ex_carry = a_q[0]; end
      OP_ROL:  ex_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OP_ROR:  ex_res = {a_q[0], a_q[WIDTH-1:1]};
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_NOR:  ex_res = ~(a_q | b_q);
      OP_NAND: ex_res = ~(a_q & b_q);
      OP_XNOR: ex_res = ~(a_q ^ b_q);
      OP_GT:   ex_res = WIDTH'(a_q > b_q);
      OP_EQ:   ex_res = WIDTH'(a_q == b_q);
      default: ex_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d   = op_t'(op);
        a_d    = a_in;
        b_d    = b_in;
        busy_d = 1'b1;
        dz_d   = 1'b0;
        if (op_t'(op) == OP_DIV && b_in != '0) begin
          div_load = 1'b1;
          state_d  = S_DIV;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = ex_res;
        rem_d    = ex_rem;
        carry_d  = ex_carry;
        zero_d   = (ex_res == '0);
        dz_d     = ex_dz;
        state_d  = S_DONE;
      end
      S_DIV: if (div_last) begin
        result_d = div_quo;
        rem_d    = div_rem;
        carry_d  = 1'b0;
        zero_d   = (div_quo == '0);
        state_d  = S_DONE;
      end
      // done is registered, so the pulse lands in the following IDLE cycle.
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = rem_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed cases plus random ops.
module tb_alu_seq;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op_i = '0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         busy, done, carry, zero, div_zero;
  logic [W-1:0] result, remainder, a_q, b_q;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a_in(a_i), .b_in(b_i),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .carry(carry), .zero(zero), .div_zero(div_zero), .a_q(a_q), .b_q(b_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int rem; bit carry; bit zero; bit dz;
    int a; int b; int lat; int cap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the op table, plain integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int r;
    e.rem = 0; e.carry = 0; e.dz = 0; e.a = a; e.b = b; e.cap = 0;
    e.lat = 2;
    r = 0;
    case (op)
      0:  begin r = a + b; e.carry = (r > MASK); end
      1:  begin r = a - b; e.carry = (a < b); end
      2:  begin r = a * b; e.carry = (r > MASK); end
      3:  if (b == 0) begin r = MASK; e.rem = a; e.dz = 1; end
          else begin r = a / b; e.rem = a % b; e.lat = W + 1; end
      4:  begin r = a * 2; e.carry = (a >= 128); end
      5:  begin r = a / 2; e.carry = (a % 2 == 1); end
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b);
      12: r = ~(a & b);
      13: r = ~(a ^ b);
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    e.res = r & MASK;
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic issue(input int op, input int a, input int b);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("issue_wait_timeout", 1, 0);
    start = 1'b1; op_i = op[3:0]; a_i = a[W-1:0]; b_i = b[W-1:0];
    e = model(op, a, b);
    @(posedge clk);
    #1;
    e.cap = cyc;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_a_q"}, int'(a_q), 0);
    chk({tag, "_b_q"}, int'(b_q), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_div_zero"}, int'(div_zero), 0);
    chk({tag, "_zero"}, int'(zero), 1);
  endtask

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("remainder", int'(remainder), e.rem);
        chk("carry", int'(carry), int'(e.carry));
        chk("zero", int'(zero), int'(e.zero));
        chk("div_zero", int'(div_zero), int'(e.dz));
        chk("a_q", int'(a_q), e.a);
        chk("b_q", int'(b_q), e.b);
        chk("latency", cyc - e.cap, e.lat);
        chk("busy_cycles", busy_cnt, e.lat);
        chk("busy_with_done", int'(busy), 0);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("rst_init");
    @(negedge clk) rst_n = 1'b1;

    issue(0, 8'hF0, 8'h20);
    issue(1, 8'h03, 8'h05);
    issue(2, 8'h10, 8'h10);
    issue(6, 8'h81, 8'h00);
    issue(5, 8'h01, 8'h00);
    issue(3, 200, 7);
    // Start held mid-DIV must be ignored.
    repeat (3) @(negedge clk);
    start = 1'b1; op_i = 4'h0; a_i = 8'h01; b_i = 8'h01;
    repeat (2) @(negedge clk);
    start = 1'b0;
    issue(3, 8'h2A, 8'h00);
    issue(0, 8'h01, 8'h02);
    issue(14, 5, 3);
    issue(15, 8'h77, 8'h77);
    issue(15, 8'h77, 8'h76);

    for (int i = 0; i < 150; i++) begin
      int o, a, b;
      o = $urandom_range(0, 15);
      a = $urandom_range(0, MASK);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      issue(o, a, b);
    end

    // Reset in the middle of a division: abort, no done afterwards.
    issue(3, 250, 3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1 check_reset_vals("rst_mid_div");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1 check_reset_vals("rst_after");

    issue(4, 8'h80, 8'h00);
    guard = 0;
    while (q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU. It performs the same 16-operation set on WIDTH-bit operands captured through a start/done handshake, and adds status flags and remainder output. Division is a multi-cycle restoring divider; every other operation completes in one cycle. It sits between the operand-entry logic (push-button steppers or the host) and the LCD/result-display path.

## Interface
- WIDTH, default 8: operand and result width; legal range 4–32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation code, captured with start.
- a_in  in  WIDTH  operand A, captured with start.
- b_in  in  WIDTH  operand B, captured with start.
- busy  out  1  high from the capture edge until done.
- done  out  1  single-cycle pulse; result and flags valid.
- result  out  WIDTH  result; held until the next capture.
- remainder  out  WIDTH  DIV remainder; 0 for all other ops.
- carry  out  1  carry/borrow/overflow-out flag.
- zero  out  1  result == 0.
- div_zero  out  1  DIV issued with B == 0.
- a_q, b_q  out  WIDTH each  captured operands, for display.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT (unsigned A>B), F EQ. GT and EQ return 1 or 0, zero-extended.
- All arithmetic is unsigned and the result is truncated to WIDTH.
- carry flag by operation:
  - ADD: carry-out.
  - SUB: borrow (A<B).
  - MUL: upper WIDTH bits of the 2·WIDTH product are nonzero.
  - SHL: A[WIDTH-1].
  - SHR: A[0].
  - All others: 0.
- FSM states are IDLE, EXEC, DIV, DONE.
  - IDLE: start=1 captures op, a_in and b_in into a_q/b_q and asserts busy. Next state is DIV if op=DIV and b_in≠0, otherwise EXEC.
  - EXEC: computes result and flags and registers them. Next state is DONE.
  - DIV: runs one restoring iteration per cycle, WIDTH iterations in total. After the last iteration, writes the quotient to result and the remainder to remainder. Next state is DONE.
  - DONE: done=1 and busy=0. Next state is IDLE.
- DIV with B=0 takes the EXEC path: result all ones, remainder = A, div_zero=1, carry=0.
- div_zero is cleared by the next capture.
- start is ignored while busy, including in DONE. No queueing.
- Reset values:
  - state is IDLE.
  - result, remainder, a_q and b_q are 0.
  - busy, done, carry and div_zero are 0.
  - zero is 1, consistent with result=0.
- rst_n asserted mid-DIV aborts immediately. After release, the block is in IDLE with reset values and no done pulse.

## Timing
- Capture happens at edge k, where start=1 in IDLE.
- Non-DIV ops: results register at edge k+1; done is high for the cycle following edge k+2.
  - Start-to-done latency is 2 cycles.
  - Next accepted start is at edge k+3 at the earliest.
- DIV with B≠0: done follows edge k+WIDTH+1, a latency of WIDTH+1 cycles.
- result, remainder and the flags change only at a result-write edge, and are stable from done until the next capture.
- busy deasserts in the same cycle done asserts.

## Structure
- alu_pkg holds:
  - the op_t enum, covering the 16 codes above;
  - the state_t enum;
  - the localparam for the all-ones value of div_zero.
- Sub-module alu_div_iter, parametrised by WIDTH:
  - ports: clk, rst_n, load, dividend, divisor, quotient, remainder, last;
  - one restoring step per cycle, using a (WIDTH+1)-bit partial remainder;
  - last is high on the final iteration.
- The top module holds the FSM, operand capture, the combinational datapath for the non-DIV ops, and the flag logic.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst_n low mid-run → all outputs match the reset values; zero=1; no done pulse.
- ADD: op=0, A=0xF0, B=0x20 → result 0x10, carry=1, zero=0, done 2 cycles after start.
  - SUB: A=0x03, B=0x05 → 0xFE, carry=1.
- MUL and shifts:
  - MUL: A=0x10, B=0x10 → result 0x00, carry=1, zero=1.
  - ROL: A=0x81 → 0x03.
  - SHR: A=0x01 → 0x00, carry=1.
- DIV: A=200, B=7 → result 28, remainder 4.
  - busy high for exactly 9 cycles, then done for 1 cycle.
  - A second start issued mid-DIV is ignored and the result is unchanged.
- DIV by zero: A=0x2A, B=0 → result 0xFF, remainder 0x2A, div_zero=1, 2-cycle latency.
  - A following ADD clears div_zero.
- Compares:
  - GT: A=5, B=3 → 1.
  - EQ: A=B=0x77 → 1.
  - EQ: A=0x77, B=0x76 → 0, zero=1.
